// File: rtl/mod_exp_seq.sv
// mod_exp_seq: sequential modular exponentiator, result = base^exponent mod modulo.
// Right-to-left square-and-multiply. Each step runs two bit-serial interleaved
// modular multipliers side by side, so there is no WIDTH x WIDTH multiplier.
// The first REDUCE cycle is an init/check cycle. It catches modulo==0.
// It is followed by WIDTH shift-subtract cycles that reduce base mod modulo.
// Optional build macro: MOD_EXP_EARLY_EXIT_EN. When it is defined, STEP ends
// as soon as the unprocessed exponent bits are all zero. When it is undefined,
// latency is fixed (constant-time).
module mod_exp_seq #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [WIDTH-1:0]     modulo,
    input  logic [EXP_WIDTH-1:0] exponent,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    output logic [1:0]           dbg_state
);
    // Handshake: start is accepted only in IDLE. busy is high from the cycle
    // after acceptance up to the done cycle. done is a one-cycle pulse, and
    // result/err stay valid from that pulse until the next accepted start.

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(EXP_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_STEP, S_FIN} state_t;

    state_t                 r_state, w_next;
    logic [WIDTH-1:0]       r_m, r_b, r_r, r_acc1, r_acc2, r_mul_sh, r_result;
    logic [EXP_WIDTH-1:0]   r_e;
    logic [CW-1:0]          r_cnt;
    logic [SW-1:0]          r_step;
    logic                   r_busy, r_done, r_err;

    logic                   w_red_init, w_cnt_last, w_last_step, w_mbit;
    logic [WIDTH:0]         w_m_ext;
    logic [WIDTH-1:0]       w_dbl1, w_dbl2, w_nxt1, w_nxt2, w_addend2;

    // One conditional subtract: valid because the operand is always < 2*m.
    function automatic logic [WIDTH-1:0] csub(input logic [WIDTH:0] x, input logic [WIDTH:0] m);
        return WIDTH'((x >= m) ? (x - m) : x);
    endfunction

    assign w_m_ext    = {1'b0, r_m};
    assign w_mbit     = r_mul_sh[WIDTH-1];
    assign w_red_init = (r_cnt == CW'(WIDTH));
    assign w_cnt_last = (r_cnt == '0);
    // REDUCE computes 1*base mod m through the same datapath: it adds 1 when the base bit is set.
    assign w_addend2  = (r_state == S_REDUCE) ? WIDTH'(1) : r_b;

    // Interleaved multiplier datapath: acc = 2*acc mod m, then + addend mod m.
    assign w_dbl1 = csub({r_acc1, 1'b0}, w_m_ext);
    assign w_dbl2 = csub({r_acc2, 1'b0}, w_m_ext);
    assign w_nxt1 = w_mbit ? csub({1'b0, w_dbl1} + {1'b0, r_r}, w_m_ext) : w_dbl1;
    assign w_nxt2 = w_mbit ? csub({1'b0, w_dbl2} + {1'b0, w_addend2}, w_m_ext) : w_dbl2;

`ifdef MOD_EXP_EARLY_EXIT_EN
    assign w_last_step = ((r_e >> 1) == '0) || (r_step == SW'(EXP_WIDTH - 1));
`else
    assign w_last_step = (r_step == SW'(EXP_WIDTH - 1));
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_REDUCE;
            S_REDUCE: begin
                if (w_red_init) begin
                    if (r_m == '0) w_next = S_FIN;
                end else if (w_cnt_last) begin
                    w_next = S_STEP;
`ifdef MOD_EXP_EARLY_EXIT_EN
                    if (r_e == '0) w_next = S_FIN;
`endif
                end
            end
            S_STEP:   if (w_cnt_last && w_last_step) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m <= '0; r_b <= '0; r_r <= '0; r_acc1 <= '0; r_acc2 <= '0;
            r_mul_sh <= '0; r_result <= '0; r_e <= '0; r_cnt <= '0; r_step <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m      <= modulo;
                        r_e      <= exponent;
                        r_mul_sh <= base;
                        r_acc1   <= '0;
                        r_acc2   <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_step   <= '0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_REDUCE: begin
                    if (w_red_init) begin
                        if (r_m == '0) begin
                            r_err <= 1'b1;
                            r_r   <= '0;
                        end
                        r_cnt <= CW'(WIDTH - 1);
                    end else begin
                        r_acc2   <= w_nxt2;
                        r_mul_sh <= {r_mul_sh[WIDTH-2:0], 1'b0};
                        r_cnt    <= r_cnt - CW'(1);
                        if (w_cnt_last) begin
                            r_b      <= w_nxt2;
                            r_mul_sh <= w_nxt2;
                            r_acc1   <= '0;
                            r_acc2   <= '0;
                            r_r      <= (r_m == WIDTH'(1)) ? '0 : WIDTH'(1);
                            r_cnt    <= CW'(WIDTH - 1);
                        end
                    end
                end
                S_STEP: begin
                    r_acc1   <= w_nxt1;
                    r_acc2   <= w_nxt2;
                    r_mul_sh <= {r_mul_sh[WIDTH-2:0], 1'b0};
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_cnt_last) begin
                        if (r_e[0]) r_r <= w_nxt1;
                        r_b      <= w_nxt2;
                        r_mul_sh <= w_nxt2;
                        r_acc1   <= '0;
                        r_acc2   <= '0;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_e      <= r_e >> 1;
                        r_step   <= r_step + SW'(1);
                    end
                end
                S_FIN: begin
                    r_result <= r_r;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign err       = r_err;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_mod_exp_seq.sv
// Testbench for mod_exp_seq: a 64-bit instance and a 16-bit instance share one clock and reset.
module tb_mod_exp_seq;
    localparam int LAT_LIMIT = 2 + 64 + 64 * 64 + 50;

    logic        clk, rst_n;
    logic        start64, busy64, done64, err64;
    logic [63:0] base64, mod64, exp64, res64;
    logic [1:0]  dbg64;
    logic        start16, busy16, done16, err16;
    logic [15:0] base16, mod16, exp16, res16;
    logic [1:0]  dbg16;

    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] exp_q[$];

    mod_exp_seq #(.WIDTH(64), .EXP_WIDTH(64)) u_dut64 (
        .clk(clk), .reset(rst_n), .start(start64), .base(base64), .modulo(mod64),
        .exponent(exp64), .busy(busy64), .done(done64), .result(res64), .err(err64),
        .dbg_state(dbg64));

    mod_exp_seq #(.WIDTH(16), .EXP_WIDTH(16)) u_dut16 (
        .clk(clk), .reset(rst_n), .start(start16), .base(base16), .modulo(mod16),
        .exponent(exp16), .busy(busy16), .done(done16), .result(res16), .err(err16),
        .dbg_state(dbg16));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain right-to-left exponentiation with wide arithmetic.
    function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] m,
                                               input logic [63:0] e, input int ew);
        logic [127:0] r, x, mm;
        if (m == 0) return 64'd0;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        x  = {64'd0, b} % mm;
        for (int i = 0; i < ew; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[63:0];
    endfunction

    function automatic int calc_lat(input int w, input int ew, input logic [63:0] m,
                                    input logic [63:0] e);
        if (m == 0) return 2;
`ifdef MOD_EXP_EARLY_EXIT_EN
        begin
            int n;
            n = 0;
            for (int i = 0; i < ew; i++) if (e[i]) n = i + 1;
            return 2 + w + n * w;
        end
`else
        if (e === 'x) return 0;
        return 2 + w + ew * w;
`endif
    endfunction

    // Driver: one operation on the chosen instance (sel=1 -> 16-bit), with an
    // optional stray start pulse poke_at cycles after acceptance.
    task automatic run_op(input bit sel, input logic [63:0] b, input logic [63:0] m,
                          input logic [63:0] e, input int poke_at, input string tag);
        int w, lat, exp_lat;
        bit seen;
        logic [63:0] want, got;
        w = sel ? 16 : 64;
        exp_q.push_back(ref_modexp(b, m, e, w));
        exp_lat = calc_lat(w, w, m, e);
        if (sel) begin
            base16 = b[15:0]; mod16 = m[15:0]; exp16 = e[15:0]; start16 = 1'b1;
        end else begin
            base64 = b; mod64 = m; exp64 = e; start64 = 1'b1;
        end
        @(posedge clk); #1;
        start16 = 1'b0; start64 = 1'b0;
        // Scramble operand inputs: they must not be resampled.
        base64 = {$urandom, $urandom}; mod64 = {$urandom, $urandom}; exp64 = {$urandom, $urandom};
        base16 = 16'($urandom); mod16 = 16'($urandom); exp16 = 16'($urandom);
        chk({tag, "/busy_rise"}, sel ? 64'(busy16) : 64'(busy64), 64'd1);
        lat = 0; seen = 1'b0;
        while (!seen && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat++;
            start16 = 1'b0; start64 = 1'b0;
            if (poke_at != 0 && lat == poke_at) begin
                if (sel) start16 = 1'b1; else start64 = 1'b1;
            end
            if (sel ? done16 : done64) seen = 1'b1;
        end
        start16 = 1'b0; start64 = 1'b0;
        want = exp_q.pop_front();
        got  = sel ? {48'd0, res16} : res64;
        chk({tag, "/done_seen"}, 64'(seen), 64'd1);
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/result"}, got, want);
        chk({tag, "/err"}, sel ? 64'(err16) : 64'(err64), 64'(m == 0));
        chk({tag, "/busy_fall"}, sel ? 64'(busy16) : 64'(busy64), 64'd0);
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, sel ? 64'(done16) : 64'(done64), 64'd0);
        got = sel ? {48'd0, res16} : res64;
        chk({tag, "/result_hold"}, got, want);
    endtask

    // Stimulus
    initial begin
        int dones;
        logic [63:0] rb, rm, re;
        rst_n = 1'b0;
        start64 = 1'b0; base64 = '0; mod64 = '0; exp64 = '0;
        start16 = 1'b0; base16 = '0; mod16 = '0; exp16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/busy", 64'(busy64), 64'd0);
        chk("reset/done", 64'(done64), 64'd0);
        chk("reset/result", res64, 64'd0);
        chk("reset/err", 64'(err64), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(1'b0, 64'd5, 64'd13, 64'd567, 0, "d_5_13_567");
        chk("d_5_13_567/value", res64, 64'd8);
        run_op(1'b0, 64'd20, 64'd13, 64'd3, 0, "d_20_13_3");
        chk("d_20_13_3/value", res64, 64'd5);
        run_op(1'b0, 64'd9, 64'd13, 64'd0, 0, "d_exp0");
        chk("d_exp0/value", res64, 64'd1);
        run_op(1'b0, 64'd7, 64'd1, 64'd9, 0, "d_mod1");
        run_op(1'b0, 64'd5, 64'd0, 64'd3, 0, "d_mod0");
        run_op(1'b0, 64'd0, 64'd97, 64'd12345, 0, "d_base0");
        run_op(1'b0, 64'd5, 64'd13, 64'd567, 100, "d_start_mid");
        chk("d_start_mid/value", res64, 64'd8);

        // Reset mid-run: aborts immediately, no done pulse afterwards.
        base64 = 64'd5; mod64 = 64'd13; exp64 = 64'd567; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/busy", 64'(busy64), 64'd0);
        chk("rst_mid/done", 64'(done64), 64'd0);
        chk("rst_mid/result", res64, 64'd0);
        chk("rst_mid/err", 64'(err64), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < LAT_LIMIT; i++) begin
            @(posedge clk); #1;
            if (done64) dones++;
        end
        chk("rst_mid/no_done", 64'(dones), 64'd0);
        chk("rst_mid/idle_busy", 64'(busy64), 64'd0);

        // 16-bit instance
        run_op(1'b1, 64'd65535, 64'd65521, 64'd65519, 0, "w16_spec");
        run_op(1'b1, 64'd3, 64'd0, 64'd3, 0, "w16_mod0");
        run_op(1'b1, 64'd65535, 64'd65535, 64'd65535, 0, "w16_max");
        for (int i = 0; i < 20; i++) begin
            rm = 64'($urandom_range(2, (i < 5) ? 20 : 65535));
            rb = 64'($urandom_range(0, 65535));
            re = 64'($urandom_range(0, 65535));
            run_op(1'b1, rb, rm, re, 0, "w16_rand");
        end

        // Random 64-bit operands
        for (int i = 0; i < 4; i++) begin
            rb = {$urandom, $urandom};
            rm = {$urandom, $urandom} | 64'd1;
            re = {$urandom, $urandom};
            if (i == 3) re = re >> 50;
            run_op(1'b0, rb, rm, re, 0, "w64_rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
